// File: rtl/sync_fifo_pkg.sv
// Shared defaults and address-width helper for the programmable-threshold synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  function automatic int addr_w(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < depth) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Handshake, data and status bundle of sync_fifo_prog; the FIFO takes the slave side.
interface sync_fifo_prog_if
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int ADDR_W = addr_w(FIFO_DEPTH);

  logic                  flush;
  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [ADDR_W:0]       af_thresh;
  logic [ADDR_W:0]       ae_thresh;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [ADDR_W:0]       count;

  modport master (
    output flush, wr_en, data_in, rd_en, af_thresh, ae_thresh,
    input  data_out, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en, af_thresh, ae_thresh,
    output data_out, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count
  );
endinterface

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, never reset.
module sync_fifo_ram #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [FIFO_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [FIFO_WIDTH-1:0] o_rdata
);
  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];

  // write port; contents survive reset and flush
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through data_out; default is registered read data.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_prog_if.slave bus
);
  localparam int ADDR_W = addr_w(FIFO_DEPTH);

  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_count;
  logic                  r_wr_ack;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [FIFO_WIDTH-1:0] w_rd_data;

  assign w_full   = (r_count == (ADDR_W+1)'(FIFO_DEPTH));
  assign w_empty  = (r_count == (ADDR_W+1)'(0));
  assign w_wr_acc = bus.wr_en & ~w_full  & ~bus.flush;
  assign w_rd_acc = bus.rd_en & ~w_empty & ~bus.flush;

  sync_fifo_ram #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  // pointers, occupancy and one-cycle status pulses; pointers wrap naturally at ADDR_W bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      r_count     <= r_count + {(ADDR_W)'(0), w_wr_acc} - {(ADDR_W)'(0), w_rd_acc};
      r_wr_ack    <= w_wr_acc;
      r_overflow  <= bus.wr_en & w_full;
      r_underflow <= bus.rd_en & w_empty;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_out = w_empty ? '0 : w_rd_data;
`else
  logic [FIFO_WIDTH-1:0] r_data_out;

  // registered read data, held between accepted reads and across flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
    end else if (w_rd_acc) begin
      r_data_out <= w_rd_data;
    end
  end

  assign bus.data_out = r_data_out;
`endif

  assign bus.count       = r_count;
  assign bus.wr_ack      = r_wr_ack;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.almostfull  = (r_count >= bus.af_thresh);
  assign bus.almostempty = (r_count <= bus.ae_thresh);
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog (16x8): queue-based reference model feeds expected
// per-cycle results to an independent monitor; directed scenarios followed by random traffic.
module tb_sync_fifo_prog;
  localparam int W = 16;
  localparam int D = 8;

  typedef struct {
    logic [W-1:0] data;
    int           cnt;
    bit           ack, ovf, udf, full, empty, af, ae;
  } rec_t;

  logic clk;
  logic rst_n;

  sync_fifo_prog_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) bus ();

  sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] last_data;
  rec_t         exp_q[$];
  int           af_v, ae_v;
  int           max_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic rec_t mk_rec(input bit ack, input bit ovf, input bit udf);
    rec_t r;
    int n;
    n       = model_q.size();
    r.data  = last_data;
    r.cnt   = n;
    r.ack   = ack;
    r.ovf   = ovf;
    r.udf   = udf;
    r.full  = (n == D);
    r.empty = (n == 0);
    r.af    = (n >= af_v);
    r.ae    = (n <= ae_v);
    return r;
  endfunction

  // one clock of stimulus; the reference model decides what the FIFO should do
  task automatic step(input bit wr, input bit rd, input bit fl, input logic [W-1:0] din);
    bit wacc, racc, ovf, udf;
    @(posedge clk);
    #3;
    bus.wr_en     = wr;
    bus.rd_en     = rd;
    bus.flush     = fl;
    bus.data_in   = din;
    bus.af_thresh = 4'(af_v);
    bus.ae_thresh = 4'(ae_v);
`ifdef SYNC_FIFO_FWFT_EN
    #1;
    if (model_q.size() > 0) chk("fwft_head", 64'(bus.data_out), 64'(model_q[0]));
`endif
    wacc = wr && !fl && (model_q.size() < D);
    racc = rd && !fl && (model_q.size() > 0);
    ovf  = wr && !fl && (model_q.size() == D);
    udf  = rd && !fl && (model_q.size() == 0);
    if (fl) begin
      model_q.delete();
    end else begin
      if (racc) last_data = model_q.pop_front();
      if (wacc) model_q.push_back(din);
    end
    if (model_q.size() > max_cnt) max_cnt = model_q.size();
    exp_q.push_back(mk_rec(wacc, ovf, udf));
  endtask

  // asynchronous reset in the middle of traffic
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    #1;
    chk("async_rst_count", 64'(bus.count), 64'd0);
    chk("async_rst_empty", 64'(bus.empty), 64'd1);
    model_q.delete();
    last_data = '0;
    exp_q.push_back(mk_rec(1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // monitor: compares every cycle's DUT outputs against the oldest expected record
  initial begin
    rec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count",       64'(bus.count),       64'(e.cnt));
        chk("wr_ack",      64'(bus.wr_ack),      64'(e.ack));
        chk("overflow",    64'(bus.overflow),    64'(e.ovf));
        chk("underflow",   64'(bus.underflow),   64'(e.udf));
        chk("full",        64'(bus.full),        64'(e.full));
        chk("empty",       64'(bus.empty),       64'(e.empty));
        chk("almostfull",  64'(bus.almostfull),  64'(e.af));
        chk("almostempty", 64'(bus.almostempty), 64'(e.ae));
`ifndef SYNC_FIFO_FWFT_EN
        chk("data_out",    64'(bus.data_out),    64'(e.data));
`endif
      end
    end
  end

  initial begin
    int wait_cycles;
    rst_n         = 1'b0;
    bus.wr_en     = 1'b0;
    bus.rd_en     = 1'b0;
    bus.flush     = 1'b0;
    bus.data_in   = '0;
    af_v          = 6;
    ae_v          = 2;
    bus.af_thresh = 4'(af_v);
    bus.ae_thresh = 4'(ae_v);
    last_data     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",    64'(bus.count),    64'd0);
    chk("rst_empty",    64'(bus.empty),    64'd1);
    chk("rst_full",     64'(bus.full),     64'd0);
    chk("rst_wr_ack",   64'(bus.wr_ack),   64'd0);
    chk("rst_data_out", 64'(bus.data_out), 64'd0);
    #2;
    rst_n = 1'b1;

    // fill 1..8 with af=6/ae=2 thresholds, then overflow+read on full, drain, underflow
    for (int i = 1; i <= D; i++) step(1'b1, 1'b0, 1'b0, 16'(i));
    step(1'b1, 1'b1, 1'b0, 16'hDEAD);
    for (int i = 0; i < D - 1; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h1234);
    step(1'b0, 1'b1, 1'b0, 16'h0);

    // flush with wr_en asserted, then fresh traffic
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h0A00 + 16'(i));
    step(1'b1, 1'b0, 1'b1, 16'hBEEF);
    step(1'b1, 1'b0, 1'b0, 16'h5A5A);
    step(1'b0, 1'b1, 1'b0, 16'h0);

    // threshold extremes: af=0 and ae beyond depth
    af_v = 0;
    ae_v = 15;
    step(1'b0, 1'b0, 1'b0, 16'h0);
    af_v = 8;
    ae_v = 0;
    step(1'b0, 1'b0, 1'b0, 16'h0);

    // random traffic with pointer wrap, changing thresholds and occasional flush
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      af_v = $urandom_range(0, 15);
      ae_v = $urandom_range(0, 15);
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
           ($urandom_range(0, 99) < 3), 16'($urandom()));
    end
    for (int i = 0; i < D + 2; i++) step(1'b0, 1'b1, 1'b0, 16'h0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("max_count_bound", 64'(max_cnt <= D), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 Parameter FIFO_WIDTH, 16, data word width in bits (1..64).
REQ-002 Parameter FIFO_DEPTH, 8, number of entries; SHALL be a power of two, 4..1024.
REQ-003 Derived constant ADDR_W = log2(FIFO_DEPTH); occupancy and thresholds are ADDR_W+1 bits wide.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 flush  in  1  synchronous clear of FIFO contents.
REQ-007 wr_en  in  1  write request.
REQ-008 data_in  in  FIFO_WIDTH  write data.
REQ-009 rd_en  in  1  read request.
REQ-010 af_thresh  in  ADDR_W+1  programmable almost-full threshold.
REQ-011 ae_thresh  in  ADDR_W+1  programmable almost-empty threshold.
REQ-012 data_out  out  FIFO_WIDTH  read data.
REQ-013 wr_ack  out  1  registered; previous-cycle write accepted.
REQ-014 overflow  out  1  registered; previous-cycle write rejected because full.
REQ-015 underflow  out  1  registered; previous-cycle read rejected because empty.
REQ-016 full, empty, almostfull, almostempty  out  1 each  combinational from count.
REQ-017 count  out  ADDR_W+1  registered occupancy, 0..FIFO_DEPTH.

Function
REQ-018 Write accepted iff wr_en && !full && !flush; read accepted iff rd_en && !empty && !flush; both decided from pre-edge state, independently.
REQ-019 On each edge, count <= count + wr_acc - rd_acc; simultaneous accepted read and write leave count unchanged.
REQ-020 Full FIFO with wr_en and rd_en: read accepted, write rejected (overflow=1), count becomes FIFO_DEPTH-1.
REQ-021 Empty FIFO with wr_en and rd_en: write accepted, read rejected (underflow=1), count becomes 1.
REQ-022 wr_ptr and rd_ptr are ADDR_W bits and wrap from FIFO_DEPTH-1 to 0 without extra logic.
REQ-023 wr_ack=1 one cycle after an accepted write, else 0; overflow=1 one cycle after wr_en while full, else 0; underflow=1 one cycle after rd_en while empty, else 0.
REQ-024 full = (count==FIFO_DEPTH); empty = (count==0); almostfull = (count >= af_thresh); almostempty = (count <= ae_thresh).
REQ-025 Threshold inputs are used unregistered and may change any cycle; af_thresh=0 forces almostfull=1; ae_thresh >= FIFO_DEPTH forces almostempty=1.
REQ-026 flush has priority over wr_en/rd_en: next edge count=0, pointers=0, wr_ack/overflow/underflow=0, memory contents not cleared, data_out unchanged.

Reset
REQ-027 While rst_n=0: count=0, wr_ptr=rd_ptr=0, data_out=0, wr_ack=overflow=underflow=0, so empty=1, full=0.
REQ-028 Reset asserted mid-operation discards all stored words immediately; first edge after deassertion behaves as empty FIFO.
REQ-029 Memory array SHALL NOT be reset.

Configuration
REQ-030 Macro SYNC_FIFO_FWFT_EN selects first-word-fall-through mode.
REQ-031 Without it: data_out is registered, updated one edge after an accepted read, and holds its value otherwise.
REQ-032 With it: data_out continuously shows the head entry mem[rd_ptr] while !empty (0 latency); an accepted read advances to the next entry at the edge; data_out value while empty is don't-care.
REQ-033 All flag, count, ack and error behaviour SHALL be identical in both modes.

Structure
REQ-034 Shared package sync_fifo_pkg holds default FIFO_WIDTH/FIFO_DEPTH constants and a function computing ADDR_W.
REQ-035 Optional sub-module sync_fifo_ram (FIFO_DEPTH x FIFO_WIDTH, one write port, one async read port) holds storage; control stays in sync_fifo_prog.

Verification (FIFO_WIDTH=16, FIFO_DEPTH=8)
REQ-036 Write 0x0001..0x0008 then read 8 -> wr_ack=1 each write, full=1 after 8th, data out 0x0001..0x0008 in order, empty=1 at end.
REQ-037 Full FIFO, wr_en=1 rd_en=1 one cycle -> overflow=1, wr_ack=0, count=7, head read returned; then empty, rd_en=1 -> underflow=1, count=0.
REQ-038 af_thresh=6, ae_thresh=2, fill 0->8 -> almostempty=1 for count 0..2, almostfull=1 for count 6..8.
REQ-039 Write 5 words, pulse flush with wr_en=1 -> count=0, empty=1, wr_ack=0; next write/read returns new word.
REQ-040 Write 20 words interleaved with reads (pointer wrap twice) -> data order preserved, count never exceeds 8; rst_n low mid-stream -> count=0 asynchronously.
REQ-041 SYNC_FIFO_FWFT_EN defined: write 0xABCD to empty FIFO -> data_out=0xABCD next cycle without rd_en; rd_en pops it, empty=1.
